// File: rtl/cpu31_pkg.sv
// rtl/cpu31_pkg.sv - shared op indices, opcode/funct constants and fetch FSM states
package cpu31_pkg;

    localparam int OP_W     = 31;
    localparam int OP_ADD   = 0;
    localparam int OP_ADDU  = 1;
    localparam int OP_SUB   = 2;
    localparam int OP_SUBU  = 3;
    localparam int OP_AND   = 4;
    localparam int OP_OR    = 5;
    localparam int OP_XOR   = 6;
    localparam int OP_NOR   = 7;
    localparam int OP_SLT   = 8;
    localparam int OP_SLTU  = 9;
    localparam int OP_SLLV  = 10;
    localparam int OP_SRLV  = 11;
    localparam int OP_SRAV  = 12;
    localparam int OP_SLL   = 13;
    localparam int OP_SRL   = 14;
    localparam int OP_SRA   = 15;
    localparam int OP_ADDI  = 16;
    localparam int OP_ADDIU = 17;
    localparam int OP_ANDI  = 18;
    localparam int OP_ORI   = 19;
    localparam int OP_XORI  = 20;
    localparam int OP_SLTI  = 21;
    localparam int OP_SLTIU = 22;
    localparam int OP_LUI   = 23;
    localparam int OP_LW    = 24;
    localparam int OP_SW    = 25;
    localparam int OP_BNE   = 26;
    localparam int OP_BEQ   = 27;
    localparam int OP_J     = 28;
    localparam int OP_JAL   = 29;
    localparam int OP_JR    = 30;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_J     = 6'h02;
    localparam logic [5:0] OPC_JAL   = 6'h03;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_SLTI  = 6'h0a;
    localparam logic [5:0] OPC_SLTIU = 6'h0b;
    localparam logic [5:0] OPC_ANDI  = 6'h0c;
    localparam logic [5:0] OPC_ORI   = 6'h0d;
    localparam logic [5:0] OPC_XORI  = 6'h0e;
    localparam logic [5:0] OPC_LUI   = 6'h0f;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational 32-bit word to one-hot op / illegal decode
module instr_decode
    import cpu31_pkg::*;
(
    input  logic [31:0]     word,
    output logic [OP_W-1:0] op,
    output logic            illegal
);

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [4:0]      rs;
    logic [4:0]      shamt;
    logic [OP_W-1:0] raw;
    logic            field_bad;
    logic            unused_fields;

    assign opcode        = word[31:26];
    assign rs            = word[25:21];
    assign shamt         = word[10:6];
    assign funct         = word[5:0];
    assign unused_fields = ^word[20:11];

    always_comb begin
        raw       = '0;
        field_bad = 1'b0;
        if (opcode == OPC_RTYPE) begin
            case (funct)
                FN_ADD:  raw[OP_ADD]  = 1'b1;
                FN_ADDU: raw[OP_ADDU] = 1'b1;
                FN_SUB:  raw[OP_SUB]  = 1'b1;
                FN_SUBU: raw[OP_SUBU] = 1'b1;
                FN_AND:  raw[OP_AND]  = 1'b1;
                FN_OR:   raw[OP_OR]   = 1'b1;
                FN_XOR:  raw[OP_XOR]  = 1'b1;
                FN_NOR:  raw[OP_NOR]  = 1'b1;
                FN_SLT:  raw[OP_SLT]  = 1'b1;
                FN_SLTU: raw[OP_SLTU] = 1'b1;
                FN_SLLV: raw[OP_SLLV] = 1'b1;
                FN_SRLV: raw[OP_SRLV] = 1'b1;
                FN_SRAV: raw[OP_SRAV] = 1'b1;
                FN_SLL:  raw[OP_SLL]  = 1'b1;
                FN_SRL:  raw[OP_SRL]  = 1'b1;
                FN_SRA:  raw[OP_SRA]  = 1'b1;
                FN_JR:   raw[OP_JR]   = 1'b1;
                default: raw = '0;
            endcase
            // Immediate shifts carry shamt but need rs=0; variable shifts may use any shamt.
            case (funct)
                FN_SLL, FN_SRL, FN_SRA:    field_bad = (rs != 5'd0);
                FN_SLLV, FN_SRLV, FN_SRAV: field_bad = 1'b0;
                default:                   field_bad = (shamt != 5'd0);
            endcase
        end else begin
            case (opcode)
                OPC_ADDI:  raw[OP_ADDI]  = 1'b1;
                OPC_ADDIU: raw[OP_ADDIU] = 1'b1;
                OPC_ANDI:  raw[OP_ANDI]  = 1'b1;
                OPC_ORI:   raw[OP_ORI]   = 1'b1;
                OPC_XORI:  raw[OP_XORI]  = 1'b1;
                OPC_SLTI:  raw[OP_SLTI]  = 1'b1;
                OPC_SLTIU: raw[OP_SLTIU] = 1'b1;
                OPC_LUI:   raw[OP_LUI]   = 1'b1;
                OPC_LW:    raw[OP_LW]    = 1'b1;
                OPC_SW:    raw[OP_SW]    = 1'b1;
                OPC_BNE:   raw[OP_BNE]   = 1'b1;
                OPC_BEQ:   raw[OP_BEQ]   = 1'b1;
                OPC_J:     raw[OP_J]     = 1'b1;
                OPC_JAL:   raw[OP_JAL]   = 1'b1;
                default:   raw = '0;
            endcase
        end
        illegal = field_bad || (raw == '0);
        op      = illegal ? '0 : raw;
    end

endmodule

// File: rtl/fetch_decode_unit.sv
// rtl/fetch_decode_unit.sv - PC owner, imem fetch handshake, decode and issue hold
// Optional FETCH_ILLEGAL_TRAP_EN: an illegal word halts the stage until reset.
module fetch_decode_unit
    import cpu31_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
)
(
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [31:0]     imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic            op_valid,
    input  logic            op_ready,
    output logic [OP_W-1:0] op,
    output logic [31:0]     instr,
    output logic [31:0]     pc,
    output logic [31:0]     pc_plus4,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    output logic            illegal,
    output logic            halted
);

    fetch_state_e    state;
    fetch_state_e    state_next;
    logic [OP_W-1:0] dec_op;
    logic            dec_illegal;
    logic            fetch_done;
    logic            accept;

    instr_decode u_decode (
        .word    (imem_rdata),
        .op      (dec_op),
        .illegal (dec_illegal)
    );

    assign imem_addr  = pc;
    assign pc_plus4   = pc + 32'd4;
    assign fetch_done = (state == FETCH) && imem_ready;
    assign accept     = (state == ISSUE) && op_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        op_valid   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
`ifdef FETCH_ILLEGAL_TRAP_EN
                    state_next = dec_illegal ? HALT : ISSUE;
`else
                    state_next = ISSUE;
`endif
                end
            end
            ISSUE: begin
                op_valid = 1'b1;
                if (op_ready) begin
                    state_next = FETCH;
                end
            end
            HALT:    state_next = HALT;
            default: state_next = FETCH;
        endcase
    end

`ifdef FETCH_ILLEGAL_TRAP_EN
    assign halted = (state == HALT);
`else
    assign halted = 1'b0;
`endif

    // Redirect is only meaningful alongside the instruction being accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            instr   <= '0;
            op      <= '0;
            illegal <= 1'b0;
        end else if (fetch_done) begin
            instr   <= imem_rdata;
            op      <= dec_op;
            illegal <= dec_illegal;
        end else if (accept) begin
            pc <= redirect_valid ? (redirect_pc & 32'hFFFF_FFFC) : pc_plus4;
        end
    end

endmodule

// File: tb/tb_fetch_decode_unit.sv
// tb/tb_fetch_decode_unit.sv - table, directed and random checks of fetch_decode_unit
module tb_fetch_decode_unit;
    import cpu31_pkg::*;

    localparam logic [31:0] RPC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        op_valid;
    logic        op_ready;
    logic [30:0] op;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        illegal;
    logic        halted;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_pc;

    always #5 clk = ~clk;

    fetch_decode_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .op_valid       (op_valid),
        .op_ready       (op_ready),
        .op             (op),
        .instr          (instr),
        .pc             (pc),
        .pc_plus4       (pc_plus4),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .illegal        (illegal),
        .halted         (halted)
    );

    // Reference decode: mnemonic tables, position in table gives the op index.
    int r_fn [17] = '{32, 33, 34, 35, 36, 37, 38, 39, 42, 43, 4, 6, 7, 0, 2, 3, 8};
    int i_op [14] = '{8, 9, 12, 13, 14, 10, 11, 15, 35, 43, 5, 4, 2, 3};

    function automatic void ref_decode(input logic [31:0] w, output logic [30:0] o, output logic ill);
        int idx;
        int opc;
        idx = -1;
        opc = int'(w[31:26]);
        if (opc == 0) begin
            for (int k = 0; k < 17; k++)
                if (int'(w[5:0]) == r_fn[k]) idx = (k == 16) ? 30 : k;
            if (idx >= 0 && !(idx >= 10 && idx <= 15) && w[10:6] != 5'd0) idx = -1;
            if (idx >= 13 && idx <= 15 && w[25:21] != 5'd0) idx = -1;
        end else begin
            for (int k = 0; k < 14; k++)
                if (opc == i_op[k]) idx = 16 + k;
        end
        ill = (idx < 0);
        o   = ill ? 31'd0 : (31'd1 << idx);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        imem_ready = 1'b0;
        op_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);
        check("rst_op_valid", 32'(op_valid), 32'd0);
        check("rst_op", {1'b0, op}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", pc, RPC);
        check("rst_imem_req", 32'(imem_req), 32'd1);
        rst = 1'b0;
        exp_pc = RPC;
    endtask

    // Entered and left at a negedge with the DUT in FETCH at exp_pc.
    task automatic fetch_one(input logic [31:0] w, input logic [30:0] eo, input logic ei,
                             input int rdly, input int sdly, input logic redir, input logic [31:0] rpc);
        for (int c = 0; c <= rdly; c++) begin
            check("fetch_req", 32'(imem_req), 32'd1);
            check("fetch_addr", imem_addr, exp_pc);
            check("fetch_op_valid", 32'(op_valid), 32'd0);
            imem_ready = (c == rdly);
            imem_rdata = (c == rdly) ? w : $urandom;
            op_ready = 1'($urandom);
            redirect_valid = 1'($urandom);
            redirect_pc = $urandom;
            @(negedge clk);
        end
`ifdef FETCH_ILLEGAL_TRAP_EN
        if (ei) begin
            for (int c = 0; c < 4; c++) begin
                check("halt_halted", 32'(halted), 32'd1);
                check("halt_req", 32'(imem_req), 32'd0);
                check("halt_op_valid", 32'(op_valid), 32'd0);
                check("halt_pc", pc, exp_pc);
                check("halt_instr", instr, w);
                imem_ready = 1'($urandom);
                op_ready = 1'b1;
                redirect_valid = 1'($urandom);
                @(negedge clk);
            end
            do_reset();
            return;
        end
`endif
        for (int c = 0; c <= sdly; c++) begin
            check("issue_op_valid", 32'(op_valid), 32'd1);
            check("issue_req", 32'(imem_req), 32'd0);
            check("issue_op", {1'b0, op}, {1'b0, eo});
            check("issue_illegal", 32'(illegal), 32'(ei));
            check("issue_instr", instr, w);
            check("issue_pc", pc, exp_pc);
            check("issue_pc_plus4", pc_plus4, exp_pc + 32'd4);
            check("issue_halted", 32'(halted), 32'd0);
            imem_ready = 1'($urandom);
            imem_rdata = $urandom;
            op_ready = (c == sdly);
            redirect_valid = (c == sdly) ? redir : 1'($urandom);
            redirect_pc = (c == sdly) ? rpc : $urandom;
            @(negedge clk);
        end
        exp_pc = redir ? {rpc[31:2], 2'b00} : exp_pc + 32'd4;
        imem_ready = 1'b0;
        op_ready = 1'b0;
        redirect_valid = 1'b0;
    endtask

    typedef struct {
        logic [31:0] word;
        logic [30:0] exp_op;
        logic        exp_ill;
    } vec_t;

    vec_t vecs [23];

    initial begin
        logic [30:0] eo;
        logic        ei;
        logic [31:0] w;

        vecs[0]  = '{32'h2008_0005, 31'd1 << 16, 1'b0};
        vecs[1]  = '{32'h0109_5020, 31'd1 << 0,  1'b0};
        vecs[2]  = '{32'h0109_5021, 31'd1 << 1,  1'b0};
        vecs[3]  = '{32'h0109_5022, 31'd1 << 2,  1'b0};
        vecs[4]  = '{32'h0109_5027, 31'd1 << 7,  1'b0};
        vecs[5]  = '{32'h0109_502B, 31'd1 << 9,  1'b0};
        vecs[6]  = '{32'h0109_5004, 31'd1 << 10, 1'b0};
        vecs[7]  = '{32'h0009_5080, 31'd1 << 13, 1'b0};
        vecs[8]  = '{32'h0029_5080, 31'd0,       1'b1};
        vecs[9]  = '{32'h0009_50C3, 31'd1 << 15, 1'b0};
        vecs[10] = '{32'h0109_5060, 31'd0,       1'b1};
        vecs[11] = '{32'h03E0_0008, 31'd1 << 30, 1'b0};
        vecs[12] = '{32'h0000_0001, 31'd0,       1'b1};
        vecs[13] = '{32'h3C08_1234, 31'd1 << 23, 1'b0};
        vecs[14] = '{32'h8C08_0004, 31'd1 << 24, 1'b0};
        vecs[15] = '{32'hAC08_0004, 31'd1 << 25, 1'b0};
        vecs[16] = '{32'h1109_0004, 31'd1 << 27, 1'b0};
        vecs[17] = '{32'h1509_0004, 31'd1 << 26, 1'b0};
        vecs[18] = '{32'h0810_0000, 31'd1 << 28, 1'b0};
        vecs[19] = '{32'h0C10_0000, 31'd1 << 29, 1'b0};
        vecs[20] = '{32'h3108_00FF, 31'd1 << 18, 1'b0};
        vecs[21] = '{32'hFC00_0000, 31'd0,       1'b1};
        vecs[22] = '{32'h2908_0001, 31'd1 << 21, 1'b0};

        do_reset();
        for (int i = 0; i < 23; i++)
            fetch_one(vecs[i].word, vecs[i].exp_op, vecs[i].exp_ill, 0, 0, 1'b0, 32'h0);

        // Stall 5 cycles on a beq, then accept it with a misaligned redirect.
        fetch_one(32'h1109_0004, 31'd1 << 27, 1'b0, 0, 5, 1'b1, 32'h0040_0103);
        check("redirect_addr", imem_addr, 32'h0040_0100);
        fetch_one(32'h2008_0005, 31'd1 << 16, 1'b0, 3, 0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        fetch_one(32'h2008_0005, 31'd1 << 16, 1'b0, 0, 0, 1'b1, 32'hFFFF_FFFC);
        fetch_one(32'h2008_0005, 31'd1 << 16, 1'b0, 0, 0, 1'b0, 32'h0);
        check("wrap_addr", imem_addr, 32'h0000_0000);

        // Reset mid-fetch: a late ready alongside rst is dropped.
        imem_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'h0109_5020;
        @(negedge clk);
        rst = 1'b0;
        imem_ready = 1'b0;
        exp_pc = RPC;
        check("rstfetch_op_valid", 32'(op_valid), 32'd0);
        check("rstfetch_addr", imem_addr, RPC);
        fetch_one(32'h0109_5022, 31'd1 << 2, 1'b0, 1, 0, 1'b0, 32'h0);

        // Reset mid-issue at 0x00400020.
        fetch_one(32'h2008_0005, 31'd1 << 16, 1'b0, 0, 0, 1'b1, 32'h0040_0020);
        check("rstissue_fetch_addr", imem_addr, 32'h0040_0020);
        imem_ready = 1'b1;
        imem_rdata = 32'h0109_5020;
        @(negedge clk);
        imem_ready = 1'b0;
        check("rstissue_valid", 32'(op_valid), 32'd1);
        check("rstissue_pc", pc, 32'h0040_0020);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_pc = RPC;
        check("rstissue_dropped", 32'(op_valid), 32'd0);
        check("rstissue_refetch", imem_addr, RPC);
        fetch_one(32'h2008_0005, 31'd1 << 16, 1'b0, 0, 0, 1'b0, 32'h0);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0: w = $urandom;
                1: begin
                    w = {6'd0, 5'($urandom_range(0, 1) * $urandom_range(0, 31)), 10'($urandom),
                         5'($urandom_range(0, 1) * $urandom_range(0, 31)), 6'(r_fn[$urandom_range(0, 16)])};
                end
                default: w = {6'(i_op[$urandom_range(0, 13)]), 26'($urandom)};
            endcase
            ref_decode(w, eo, ei);
            fetch_one(w, eo, ei, $urandom_range(0, 2), $urandom_range(0, 2),
                      ($urandom_range(0, 3) == 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_decode_unit.md
# fetch_decode_unit

Instruction fetch and decode stage for the 31-instruction MIPS core. It sits directly upstream of the control unit. It owns the PC and fetches words from instruction memory over a request/ready handshake. It decodes each word into the 31-bit one-hot `op` vector the control unit consumes, then holds it stable until the downstream stage accepts it.

## Interface
- `RESET_PC`, default `32'h0040_0000`: PC value loaded on reset.
- `clk  in  1`: single clock; all state updates on rising edge.
- `rst  in  1`: reset is synchronous and active-high.
- `imem_req  out  1`: fetch request to instruction memory.
- `imem_addr  out  32`: word address of the fetch; always equals `pc`.
- `imem_ready  in  1`: memory returns `imem_rdata` this cycle; ignored when `imem_req`=0.
- `imem_rdata  in  32`: fetched instruction word.
- `op_valid  out  1`: `op`, `instr`, `pc` and `pc_plus4` hold a decoded instruction.
- `op_ready  in  1`: downstream accepts the current instruction this cycle.
- `op  out  31`: one-hot decode; all-zero for an illegal word.
- `instr  out  32`: raw instruction register, for immediate, shamt and register fields.
- `pc  out  32`: address of `instr`.
- `pc_plus4  out  32`: `pc + 4`, for the `jal` link.
- `redirect_valid  in  1`: take a branch or jump to `redirect_pc`.
- `redirect_pc  in  32`: target address; bits [1:0] are forced to 0.
- `illegal  out  1`: the current `instr` does not decode.
- `halted  out  1`: stage is stopped on an illegal instruction (trap build only).

## Operation
- `op` index map, fixed:
  - 0 add, 1 addu, 2 sub, 3 subu, 4 and, 5 or, 6 xor, 7 nor
  - 8 slt, 9 sltu, 10 sllv, 11 srlv, 12 srav, 13 sll, 14 srl, 15 sra
  - 16 addi, 17 addiu, 18 andi, 19 ori, 20 xori, 21 slti, 22 sltiu, 23 lui
  - 24 lw, 25 sw, 26 bne, 27 beq, 28 j, 29 jal, 30 jr
- Decode rules:
  - R-type is opcode 0 with the matching funct.
  - shamt must be 0 for non-shift R-type; violating words are illegal.
  - rs must be 0 for sll/srl/sra; violating words are illegal.
- FSM states FETCH, ISSUE, HALT.
  - **FETCH**:
    - `imem_req`=1 and `op_valid`=0.
    - On `imem_ready`, latch `imem_rdata` into `instr` and the decoded value into `op`/`illegal`, then go to ISSUE.
  - **ISSUE**:
    - `imem_req`=0 and `op_valid`=1; outputs stay stable until accepted.
    - Accept is `op_valid & op_ready`. On accept, `pc` ← `redirect_valid ? {redirect_pc[31:2],2'b00} : pc+4`, then go to FETCH.
  - **HALT**: trap build only; terminal until `rst`.
- `redirect_valid` is sampled only on an accept cycle and ignored at all other times. The datapath must hold it with the instruction it resolves.
- PC arithmetic is modulo 2^32. PC `32'hFFFF_FFFC` + 4 wraps to 0 with no flag.

## Timing
- Reset values:
  - `pc`=`RESET_PC`, state FETCH, `imem_req`=1 on the first cycle after reset.
  - `op_valid`=0, `op`=0, `instr`=0, `illegal`=0, `halted`=0.
- Latency:
  - `imem_ready` in cycle N gives `op_valid` in cycle N+1.
  - Accept in cycle M gives `imem_req` with the new `imem_addr` in cycle M+1.
- Throughput with a zero-wait memory (`imem_ready` tied 1) and `op_ready` tied 1: one instruction every 2 cycles.
- Reset mid-fetch: the pending request is abandoned. A late `imem_ready` is only honoured for the post-reset request at `RESET_PC`.
- Reset while in ISSUE: the instruction is dropped and `op_valid` falls in the cycle after `rst` is sampled.
- `op_ready` held high outside ISSUE has no effect.

## Configuration
- `FETCH_ILLEGAL_TRAP_EN` defined:
  - Entering ISSUE with `illegal`=1 goes instead to HALT.
  - In HALT: `op_valid`=0, `imem_req`=0, `halted`=1; `pc` and `instr` keep the offending values.
- Undefined:
  - An illegal word issues normally with `op`=0, which executes as a no-op with no register write.
  - `halted` is tied 0.

## Structure
- Shared package `cpu31_pkg` holds:
  - `localparam` `OP_*` indices 0..30 and `OP_W`=31.
  - Opcode and funct constants.
  - `RESET_PC` default.
  - FSM state enum.
- Sub-module `instr_decode`: purely combinational, 32-bit word → {`op`, `illegal`}. It is instantiated once on `imem_rdata` and is reusable by the bench as a reference model.

## Test plan
- Reset, zero-wait memory returning `32'h2008_0005` (addi), `op_ready`=1 → `imem_addr`=`32'h0040_0000`; `op_valid` in cycle 2 with `op`=`1<<16`; next `imem_addr`=`32'h0040_0004`.
- Hold `op_ready`=0 for 5 cycles in ISSUE → `op`, `pc` and `instr` stable, no new `imem_req`; release → exactly one accept.
- Accept a `beq` with `redirect_valid`=1 and `redirect_pc`=`32'h0040_0103` → next `imem_addr`=`32'h0040_0100`. Pulse `redirect_valid` during FETCH → no effect.
- `imem_ready` delayed 3 cycles → `imem_req` and `imem_addr` held steady throughout; `op_valid` one cycle after ready.
- Word `32'hFC00_0000`:
  - trap build → `halted`=1, `imem_req`=0 permanently until `rst`;
  - default build → `op_valid`=1, `op`=0, `illegal`=1, fetch continues at `pc+4`.
- Assert `rst` mid-ISSUE at `pc`=`32'h0040_0020` → next cycle `op_valid`=0; following fetch at `32'h0040_0000`.
